// File: rtl/pc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pc_pkg
// Purpose  : Shared next-PC select codes, sequencer state type, default vectors.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
package pc_pkg;

  localparam logic [2:0] SEL_SEQ    = 3'd0;
  localparam logic [2:0] SEL_BRANCH = 3'd1;
  localparam logic [2:0] SEL_JUMP   = 3'd2;
  localparam logic [2:0] SEL_JREG   = 3'd3;
  localparam logic [2:0] SEL_EXC    = 3'd4;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_EXC_VEC  = 32'h0000_4180;

endpackage
`default_nettype wire

// File: rtl/pc_target_calc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pc_target_calc
// Purpose  : Combinational next-PC target selection and redirect detection.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int          WIDTH   = 32,
  parameter logic [31:0] EXC_VEC = DEFAULT_EXC_VEC
) (
  input  logic [WIDTH-1:0] pc4,
  input  logic [2:0]       sel,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic [25:0]      j_index,
  input  logic [WIDTH-1:0] jr_addr,
  output logic [WIDTH-1:0] target,
  output logic             redirect
);

  logic [31:0] w_pc4_ext;
  logic [31:0] w_jump_full;

  // Build the jump in a 32-bit frame so narrow WIDTH just truncates it.
  assign w_pc4_ext   = 32'(pc4);
  assign w_jump_full = {w_pc4_ext[31:28], j_index, 2'b00};

  always_comb begin
    target   = pc4;
    redirect = 1'b0;
    case (sel)
      SEL_BRANCH: begin
        if (br_taken) begin
          target   = br_target;
          redirect = 1'b1;
        end
      end
      SEL_JUMP: begin
        target   = w_jump_full[WIDTH-1:0];
        redirect = 1'b1;
      end
      SEL_JREG: begin
        target   = jr_addr;
        redirect = 1'b1;
      end
      SEL_EXC: begin
        target   = EXC_VEC[WIDTH-1:0];
        redirect = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pc_sequencer
// Purpose  : Program counter with stall, deferred redirect and misalign trap.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] EXC_VEC  = DEFAULT_EXC_VEC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [2:0]       sel,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic [25:0]      j_index,
  input  logic [WIDTH-1:0] jr_addr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc4,
  output logic             misalign,
  output logic             pending
);

  localparam logic [WIDTH-1:0] C_EXC_VEC  = EXC_VEC[WIDTH-1:0];
  localparam logic [WIDTH-1:0] C_RESET_PC = RESET_PC[WIDTH-1:0];

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] pc_q,        pc_d;
  logic [WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic             pend_exc_q,  pend_exc_d;
  logic             pending_q,   pending_d;
  logic             misalign_q,  misalign_d;

  logic [WIDTH-1:0] w_target;
  logic             w_redirect;
  logic             w_sel_exc;

  logic             load_en;
  logic             load_chk;
  logic [WIDTH-1:0] load_addr;

  assign pc4       = pc_q + WIDTH'(32'd4);
  assign w_sel_exc = (sel == SEL_EXC);

  pc_target_calc #(
    .WIDTH   (WIDTH),
    .EXC_VEC (EXC_VEC)
  ) u_target_calc (
    .pc4       (pc4),
    .sel       (sel),
    .br_taken  (br_taken),
    .br_target (br_target),
    .j_index   (j_index),
    .jr_addr   (jr_addr),
    .target    (w_target),
    .redirect  (w_redirect)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_addr_d = pend_addr_q;
    pend_exc_d  = pend_exc_q;
    pending_d   = pending_q;
    misalign_d  = 1'b0;
    load_en     = 1'b0;
    load_chk    = 1'b0;
    load_addr   = pc_q;

    case (state_q)
      ST_RUN: begin
        if (!stall) begin
          load_en   = 1'b1;
          load_addr = w_target;
          load_chk  = !w_sel_exc;
        end else if (w_redirect) begin
          pend_addr_d = w_target;
          pend_exc_d  = w_sel_exc;
          pending_d   = 1'b1;
          state_d     = ST_HELD;
        end
      end
      ST_HELD: begin
        if (!stall) begin
          load_en   = 1'b1;
          load_addr = w_sel_exc ? C_EXC_VEC : pend_addr_q;
          load_chk  = !w_sel_exc && !pend_exc_q;
          pend_exc_d = 1'b0;
          pending_d  = 1'b0;
          state_d    = ST_RUN;
        end else if (w_redirect && (w_sel_exc || !pend_exc_q)) begin
          // A captured exception is sticky against later non-exception redirects.
          pend_addr_d = w_target;
          pend_exc_d  = w_sel_exc;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (load_en) begin
      if (load_chk && (load_addr[1:0] != 2'b00)) begin
        pc_d       = C_EXC_VEC;
        misalign_d = 1'b1;
      end else begin
        pc_d = load_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      pc_q        <= C_RESET_PC;
      pend_addr_q <= '0;
      pend_exc_q  <= 1'b0;
      pending_q   <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_addr_q <= pend_addr_d;
      pend_exc_q  <= pend_exc_d;
      pending_q   <= pending_d;
      misalign_q  <= misalign_d;
    end
  end

  assign pc       = pc_q;
  assign misalign = misalign_q;
  assign pending  = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench: directed scenarios plus randomized traffic
//            compared every cycle against a behavioural next-PC model.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC    = 32'h0000_4180;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [2:0]  sel;
  logic        br_taken;
  logic [31:0] br_target;
  logic [25:0] j_index;
  logic [31:0] jr_addr;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        misalign;
  logic        pending;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  bit          m_held;
  logic [31:0] m_pend;
  bit          m_pend_exc;
  bit          m_mis;

  pc_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .sel       (sel),
    .br_taken  (br_taken),
    .br_target (br_target),
    .j_index   (j_index),
    .jr_addr   (jr_addr),
    .pc        (pc),
    .pc4       (pc4),
    .misalign  (misalign),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_target(input logic [31:0] p, input logic [2:0] s,
                                               input logic bt, input logic [31:0] bta,
                                               input logic [25:0] ji, input logic [31:0] jr);
    logic [31:0] n;
    n = p + 32'd4;
    if (s == 3'd1 && bt) return bta;
    if (s == 3'd2)       return {n[31:28], ji, 2'b00};
    if (s == 3'd3)       return jr;
    if (s == 3'd4)       return EXC;
    return n;
  endfunction

  // Reference model: what the PC must become from the rules, edge by edge
  initial begin
    logic [31:0] t;
    logic [31:0] nxt;
    bit          redir;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_pc = RST_PC; m_held = 0; m_pend = '0; m_pend_exc = 0; m_mis = 0;
      end else begin
        t     = model_target(m_pc, sel, br_taken, br_target, j_index, jr_addr);
        redir = (sel == 3'd2) || (sel == 3'd3) || (sel == 3'd4) || (sel == 3'd1 && br_taken);
        m_mis = 0;
        if (stall) begin
          if (redir && (!m_held || sel == 3'd4 || !m_pend_exc)) begin
            m_pend = t; m_pend_exc = (sel == 3'd4); m_held = 1;
          end
        end else begin
          if (m_held) nxt = (sel == 3'd4) ? EXC : m_pend;
          else        nxt = t;
          m_held = 0;
          if (nxt[1:0] != 2'b00) begin
            nxt = EXC; m_mis = 1;
          end
          m_pc = nxt;
        end
      end
    end
  end

  // Per-cycle comparison away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        check("pc",       pc,               m_pc);
        check("pc4",      pc4,              m_pc + 32'd4);
        check("misalign", {31'd0, misalign}, {31'd0, m_mis});
        check("pending",  {31'd0, pending},  {31'd0, m_held});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    #2 reset = 1'b1;
    #1 reset = 1'b0;
  endtask

  task automatic idle_inputs;
    stall = 0; sel = 3'd0; br_taken = 0; br_target = '0; j_index = '0; jr_addr = '0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    started = 1;
    #1;
    check("rst_pc", pc, RST_PC);
    check("rst_pending", {31'd0, pending}, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    reset = 1'b0;

    // Sequential fetch after reset
    tick(); check("seq1", pc, 32'h3004);
    tick(); check("seq2", pc, 32'h3008);
    tick(); check("seq3", pc, 32'h300C);

    // Jump then not-taken branch from 0x3008
    pulse_reset(); check("rst_pulse", pc, RST_PC);
    tick(); tick(); check("pre_jump", pc, 32'h3008);
    sel = 3'd2; j_index = 26'h0000C04;
    tick(); check("jump", pc, 32'h3010);
    sel = 3'd1; br_taken = 0; br_target = 32'h3100;
    tick(); check("br_not_taken", pc, 32'h3014);

    // Redirect captured under stall, released later
    idle_inputs(); pulse_reset();
    stall = 1; sel = 3'd3; jr_addr = 32'h3200;
    tick(); check("held_pc", pc, 32'h3000); check("held_pend", {31'd0, pending}, 32'd1);
    stall = 0; sel = 3'd0;
    tick(); check("release_pc", pc, 32'h3200); check("release_pend", {31'd0, pending}, 32'd0);

    // Misaligned register jump traps
    sel = 3'd3; jr_addr = 32'h3202;
    tick(); check("mis_pc", pc, EXC); check("mis_flag", {31'd0, misalign}, 32'd1);
    sel = 3'd0;
    tick(); check("mis_clear", {31'd0, misalign}, 32'd0); check("after_mis", pc, 32'h4184);

    // Sticky exception while held
    stall = 1; sel = 3'd4;
    tick(); check("exc_pend", {31'd0, pending}, 32'd1); check("exc_hold", pc, 32'h4184);
    sel = 3'd2; j_index = 26'h0000C04;
    tick(); check("exc_sticky_pend", {31'd0, pending}, 32'd1);
    stall = 0; sel = 3'd0;
    tick(); check("exc_release", pc, EXC);

    // Misaligned pending address trapped at release, not at capture
    stall = 1; sel = 3'd3; jr_addr = 32'h3201;
    tick(); check("mis_capture_flag", {31'd0, misalign}, 32'd0);
    stall = 0; sel = 3'd0;
    tick(); check("mis_pend_pc", pc, EXC); check("mis_pend_flag", {31'd0, misalign}, 32'd1);

    // Asynchronous reset while held
    stall = 1; sel = 3'd3; jr_addr = 32'h5000;
    tick(); check("held_b4_rst", {31'd0, pending}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_pc", pc, RST_PC); check("async_rst_pend", {31'd0, pending}, 32'd0);
    reset = 1'b0;
    idle_inputs();
    tick(); check("post_rst_seq", pc, 32'h3004);

    // Wrap of pc4 at the top of the address space
    sel = 3'd3; jr_addr = 32'hFFFF_FFFC;
    tick(); check("top_pc", pc, 32'hFFFF_FFFC); check("top_pc4", pc4, 32'h0);
    sel = 3'd0;
    tick(); check("wrap_pc", pc, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      stall     = ($urandom_range(0, 9) < 3);
      sel       = 3'($urandom_range(0, 7));
      br_taken  = 1'($urandom_range(0, 1));
      br_target = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      jr_addr   = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      j_index   = 26'($urandom);
      if ($urandom_range(0, 299) == 0) pulse_reset();
      tick();
    end

    idle_inputs();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
